// File: rtl/img_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | img_pkg : shared pixel/window widths and read-FSM state encoding         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package img_pkg;
    localparam int PIX_W   = 8;
    localparam int WIN_PIX = 9;
    localparam int WIN_W   = PIX_W * WIN_PIX;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_e;
endpackage
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | line_buffer : one image line with a self-advancing write port and a      |
// | combinational 3-tap read. Revision: 1.0                                  |
// +--------------------------------------------------------------------------+
module line_buffer
    import img_pkg::*;
#(
    parameter int  IMG_WIDTH = 512,
    localparam int COL_W     = $clog2(IMG_WIDTH)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               wr_en_i,
    input  logic [PIX_W-1:0]   wr_data_i,
    output logic               wr_last_o,
    input  logic [COL_W-1:0]   rd_col_i,
    output logic [3*PIX_W-1:0] taps_o
);
    logic [PIX_W-1:0] mem_q [IMG_WIDTH];
    logic [COL_W-1:0] wr_ptr_q;
    logic [COL_W-1:0] wr_ptr_d;

    assign wr_last_o = (wr_ptr_q == COL_W'(IMG_WIDTH - 1));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (wr_en_i) begin
            wr_ptr_d = wr_last_o ? '0 : wr_ptr_q + COL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Storage is deliberately left out of reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign taps_o = {mem_q[rd_col_i + COL_W'(2)],
                     mem_q[rd_col_i + COL_W'(1)],
                     mem_q[rd_col_i]};
endmodule
`default_nettype wire

// File: rtl/window_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | window_gen : buffers a pixel raster in 4 rotating lines and emits one    |
// | 3x3 neighbourhood per cycle. Revision: 1.0                               |
// +--------------------------------------------------------------------------+
module window_gen
    import img_pkg::*;
#(
    parameter int IMG_WIDTH = 512
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [PIX_W-1:0] i_pixel_data,
    input  logic             i_pixel_data_valid,
    output logic             o_ready,
    output logic [WIN_W-1:0] pixel_data,
    output logic             pixel_data_valid,
    output logic             o_intr
);
    localparam int NUM_LB = 4;
    localparam int COL_W  = $clog2(IMG_WIDTH);
    localparam int FILL_W = $clog2(NUM_LB * IMG_WIDTH + 1);
    localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(NUM_LB * IMG_WIDTH);
    localparam logic [FILL_W-1:0] FILL_START = FILL_W'(3 * IMG_WIDTH);
    localparam logic [FILL_W-1:0] LINE_PIX   = FILL_W'(IMG_WIDTH);
    localparam logic [COL_W-1:0]  RD_LAST    = COL_W'(IMG_WIDTH - 3);

    rd_state_e         state_q, state_d;
    logic [1:0]        wr_sel_q, wr_sel_d;
    logic [1:0]        rd_sel_q, rd_sel_d;
    logic [COL_W-1:0]  rd_col_q, rd_col_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [WIN_W-1:0]  pixel_data_q, pixel_data_d;
    logic              valid_q, valid_d;
    logic              intr_q, intr_d;

    logic               accept;
    logic               line_done;
    logic [NUM_LB-1:0]  lb_wr_en;
    logic [NUM_LB-1:0]  lb_wr_last;
    logic [3*PIX_W-1:0] lb_taps [NUM_LB];
    logic [WIN_W-1:0]   window;

    assign o_ready = (fill_q < FILL_FULL);
    assign accept  = i_pixel_data_valid && o_ready;

    for (genvar i = 0; i < NUM_LB; i++) begin : g_lb
        assign lb_wr_en[i] = accept && (wr_sel_q == 2'(i));

        line_buffer #(
            .IMG_WIDTH (IMG_WIDTH)
        ) u_line_buffer (
            .clk       (clk),
            .rstn      (rstn),
            .wr_en_i   (lb_wr_en[i]),
            .wr_data_i (i_pixel_data),
            .wr_last_o (lb_wr_last[i]),
            .rd_col_i  (rd_col_q),
            .taps_o    (lb_taps[i])
        );
    end

    // The 2-bit selector wraps naturally, giving the mod-4 line rotation.
    assign window = {lb_taps[rd_sel_q + 2'd2],
                     lb_taps[rd_sel_q + 2'd1],
                     lb_taps[rd_sel_q]};

    always_comb begin
        state_d      = state_q;
        rd_col_d     = rd_col_q;
        rd_sel_d     = rd_sel_q;
        line_done    = 1'b0;
        valid_d      = 1'b0;
        pixel_data_d = pixel_data_q;
        case (state_q)
            IDLE: begin
                if (fill_q >= FILL_START) begin
                    state_d  = READ;
                    rd_col_d = '0;
                end
            end
            READ: begin
                valid_d      = 1'b1;
                pixel_data_d = window;
                if (rd_col_q == RD_LAST) begin
                    line_done = 1'b1;
                    state_d   = IDLE;
                    rd_col_d  = '0;
                    rd_sel_d  = rd_sel_q + 2'd1;
                end else begin
                    rd_col_d = rd_col_q + COL_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        intr_d = line_done;
    end

    // Accept and line release can coincide; both terms apply in one update.
    always_comb begin
        fill_d   = fill_q;
        wr_sel_d = wr_sel_q;
        if (accept) begin
            fill_d = fill_d + FILL_W'(1);
            if (lb_wr_last[wr_sel_q]) begin
                wr_sel_d = wr_sel_q + 2'd1;
            end
        end
        if (line_done) begin
            fill_d = fill_d - LINE_PIX;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            wr_sel_q     <= '0;
            rd_sel_q     <= '0;
            rd_col_q     <= '0;
            fill_q       <= '0;
            pixel_data_q <= '0;
            valid_q      <= 1'b0;
            intr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_sel_q     <= wr_sel_d;
            rd_sel_q     <= rd_sel_d;
            rd_col_q     <= rd_col_d;
            fill_q       <= fill_d;
            pixel_data_q <= pixel_data_d;
            valid_q      <= valid_d;
            intr_q       <= intr_d;
        end
    end

    assign pixel_data       = pixel_data_q;
    assign pixel_data_valid = valid_q;
    assign o_intr           = intr_q;
endmodule
`default_nettype wire

// File: tb/tb_window_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_window_gen : directed self-checking bench for window_gen, width 8.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_window_gen;
    import img_pkg::*;

    localparam int W = 8;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [PIX_W-1:0] i_pixel_data = '0;
    logic             i_pixel_data_valid = 1'b0;
    logic             o_ready;
    logic [WIN_W-1:0] pixel_data;
    logic             pixel_data_valid;
    logic             o_intr;

    int checks = 0;
    int errors = 0;

    logic [WIN_W-1:0] rec_win [$];
    logic             rec_intr [$];
    int               stray_intr = 0;

    always #5 clk = ~clk;

    window_gen #(
        .IMG_WIDTH (W)
    ) dut (
        .clk                (clk),
        .rstn               (rstn),
        .i_pixel_data       (i_pixel_data),
        .i_pixel_data_valid (i_pixel_data_valid),
        .o_ready            (o_ready),
        .pixel_data         (pixel_data),
        .pixel_data_valid   (pixel_data_valid),
        .o_intr             (o_intr)
    );

    always @(negedge clk) begin
        if (rstn && pixel_data_valid) begin
            rec_win.push_back(pixel_data);
            rec_intr.push_back(o_intr);
        end
        if (o_intr && !pixel_data_valid) stray_intr++;
    end

    // Reference 3x3 extraction from the input formula pixel = line*16 + col.
    function automatic logic [WIN_W-1:0] exp_win(input int ln, input int c);
        logic [WIN_W-1:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++)
                w[(r*3+k)*8 +: 8] = 8'((ln + r) * 16 + c + k);
        return w;
    endfunction

    task automatic apply_reset();
        i_pixel_data_valid = 1'b0;
        i_pixel_data       = '0;
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_lines(input int n_lines, input int max_gap);
        for (int ln = 0; ln < n_lines; ln++) begin
            for (int c = 0; c < W; c++) begin
                int   gap;
                int   tmo;
                logic took;
                gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
                i_pixel_data_valid = 1'b0;
                repeat (gap) begin @(posedge clk); #1; end
                i_pixel_data       = 8'(ln * 16 + c);
                i_pixel_data_valid = 1'b1;
                tmo = 0;
                do begin
                    took = o_ready;
                    @(posedge clk);
                    #1;
                    tmo++;
                end while (!took && tmo < 200);
                if (!took) begin
                    errors++;
                    $display("FAIL send_timeout: o_ready=0 for %0d cycles, required 1", tmo);
                end
            end
        end
        i_pixel_data_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_pixel_data_valid = 1'b0;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b required 1", o_ready); end
        checks++; if (pixel_data !== '0) begin errors++; $display("FAIL rst_data: got %h required 0", pixel_data); end
        checks++; if (pixel_data_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", pixel_data_valid); end
        checks++; if (o_intr !== 1'b0) begin errors++; $display("FAIL rst_intr: got %b required 0", o_intr); end
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (pixel_data_valid !== 1'b0) begin errors++; $display("FAIL rst_idle_valid: got %b required 0", pixel_data_valid); end
    endtask

    task automatic test_first_line();
        logic [WIN_W-1:0] exp;
        apply_reset();
        send_lines(3, 0);
        @(negedge clk);
        checks++; if (pixel_data_valid !== 1'b0) begin errors++; $display("FAIL lat_edge1: valid got %b required 0", pixel_data_valid); end
        @(negedge clk);
        checks++; if (pixel_data_valid !== 1'b0) begin errors++; $display("FAIL lat_edge2: valid got %b required 0", pixel_data_valid); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0)      exp = 72'h22_21_20_12_11_10_02_01_00;
            else if (k == 5) exp = 72'h27_26_25_17_16_15_07_06_05;
            else             exp = exp_win(0, k);
            checks++; if (pixel_data_valid !== 1'b1) begin errors++; $display("FAIL line0_valid[%0d]: got %b required 1", k, pixel_data_valid); end
            checks++; if (pixel_data !== exp) begin errors++; $display("FAIL line0_win[%0d]: got %h required %h", k, pixel_data, exp); end
            checks++; if (o_intr !== (k == 5)) begin errors++; $display("FAIL line0_intr[%0d]: got %b required %b", k, o_intr, (k == 5)); end
        end
        @(negedge clk);
        checks++; if (pixel_data_valid !== 1'b0) begin errors++; $display("FAIL line0_gap: valid got %b required 0", pixel_data_valid); end
        checks++; if (pixel_data !== 72'h27_26_25_17_16_15_07_06_05) begin errors++; $display("FAIL line0_hold: got %h required 272625171615070605", pixel_data); end
        checks++; if (o_intr !== 1'b0) begin errors++; $display("FAIL line0_intr_end: got %b required 0", o_intr); end
    endtask

    task automatic test_dense_stream();
        int base;
        int ready_low;
        int n;
        apply_reset();
        base      = rec_win.size();
        ready_low = 0;
        for (int i = 0; i < 4 * W; i++) begin
            i_pixel_data       = 8'((i / W) * 16 + (i % W));
            i_pixel_data_valid = 1'b1;
            if (!o_ready) ready_low++;
            @(posedge clk);
            #1;
        end
        i_pixel_data_valid = 1'b0;
        repeat (30) @(negedge clk);
        checks++; if (ready_low !== 0) begin errors++; $display("FAIL dense_ready: low %0d cycles, required 0", ready_low); end
        n = rec_win.size() - base;
        checks++; if (n !== 2 * (W - 2)) begin errors++; $display("FAIL dense_count: got %0d required %0d", n, 2 * (W - 2)); end
        for (int i = 0; i < n && i < 2 * (W - 2); i++) begin
            checks++;
            if (rec_win[base+i] !== exp_win(i / (W - 2), i % (W - 2))) begin
                errors++; $display("FAIL dense_win[%0d]: got %h required %h", i, rec_win[base+i], exp_win(i / (W - 2), i % (W - 2)));
            end
        end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL dense_ready_end: got %b required 1", o_ready); end
    endtask

    task automatic test_stream(input string name, input int n_lines, input int max_gap);
        int base;
        int stray0;
        int tmo;
        int n;
        int want;
        apply_reset();
        base   = rec_win.size();
        stray0 = stray_intr;
        want   = (n_lines - 2) * (W - 2);
        send_lines(n_lines, max_gap);
        tmo = 0;
        while ((rec_win.size() - base) < want && tmo < 400) begin
            @(negedge clk);
            tmo++;
        end
        repeat (20) @(negedge clk);
        n = rec_win.size() - base;
        checks++; if (n !== want) begin errors++; $display("FAIL %s_count: got %0d required %0d", name, n, want); end
        for (int i = 0; i < n && i < want; i++) begin
            checks++;
            if (rec_win[base+i] !== exp_win(i / (W - 2), i % (W - 2)) ||
                rec_intr[base+i] !== ((i % (W - 2)) == W - 3)) begin
                errors++;
                $display("FAIL %s_win[%0d]: got %h intr %b required %h intr %b", name, i,
                         rec_win[base+i], rec_intr[base+i], exp_win(i / (W - 2), i % (W - 2)),
                         ((i % (W - 2)) == W - 3));
            end
        end
        checks++; if (stray_intr !== stray0) begin errors++; $display("FAIL %s_stray_intr: got %0d required %0d", name, stray_intr, stray0); end
    endtask

    task automatic test_async_reset();
        logic [WIN_W-1:0] exp;
        apply_reset();
        send_lines(3, 0);
        repeat (3) @(negedge clk);
        checks++; if (pixel_data_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid: got %b required 1", pixel_data_valid); end
        #2;
        rstn = 1'b0;
        #1;
        checks++; if (pixel_data !== '0) begin errors++; $display("FAIL arst_data: got %h required 0", pixel_data); end
        checks++; if (pixel_data_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b required 0", pixel_data_valid); end
        checks++; if (o_intr !== 1'b0) begin errors++; $display("FAIL arst_intr: got %b required 0", o_intr); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL arst_ready: got %b required 1", o_ready); end
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        send_lines(3, 0);
        repeat (2) @(negedge clk);
        checks++; if (pixel_data_valid !== 1'b0) begin errors++; $display("FAIL arst_lat: valid got %b required 0", pixel_data_valid); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0)      exp = 72'h22_21_20_12_11_10_02_01_00;
            else if (k == 5) exp = 72'h27_26_25_17_16_15_07_06_05;
            else             exp = exp_win(0, k);
            checks++;
            if (pixel_data_valid !== 1'b1 || pixel_data !== exp || o_intr !== (k == 5)) begin
                errors++;
                $display("FAIL arst_win[%0d]: got v=%b %h i=%b required v=1 %h i=%b", k,
                         pixel_data_valid, pixel_data, o_intr, exp, (k == 5));
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_dense_stream();
        test_stream("long", 12, 0);
        test_async_reset();
        test_stream("gaps", 10, 3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
